// File: rtl/enemy_spawner.sv
// enemy_spawner: turns spawn requests into enemies in the packed object table, scrolls live
// enemies left on movement ticks and retires those that reach the left screen edge.
module enemy_spawner #(
  parameter int DATACOUNT = 8,
  parameter int TYPELEN   = 3,
  parameter int XLEN      = 10,
  parameter int YLEN      = 9,
  parameter int WLEN      = 6,
  parameter int HLEN      = 6,
  parameter int SPAWN_X   = 640,
  parameter int GROUND_Y  = 400
) (
  input  logic                                                 clock,
  input  logic                                                 rst,
  input  logic                                                 togenerate,
  input  logic                                                 tick,
  input  logic [3:0]                                           speed,
  input  logic                                                 halt,
  output logic [(TYPELEN+XLEN+YLEN+WLEN+HLEN)*DATACOUNT-1:0]   gamedata,
  output logic [3:0]                                           active_count,
  output logic                                                 spawn_drop,
  output logic [1:0]                                           o_dbg_state
);
  localparam int SLOTW = TYPELEN + XLEN + YLEN + WLEN + HLEN;
  localparam int IDXW  = (DATACOUNT > 1) ? $clog2(DATACOUNT) : 1;
  localparam int XLSB  = YLEN + WLEN + HLEN;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SPAWN = 2'd1, S_MOVE = 2'd2} state_t;

  state_t             r_state;
  logic [SLOTW-1:0]   r_slots [DATACOUNT];
  logic [IDXW-1:0]    r_idx;
  logic [15:0]        r_lfsr;
  logic               r_tog_prev;
  logic               r_pend_spawn;
  logic               r_pend_move;

  logic               w_req;
  logic               w_tick;
  logic               w_free_found;
  logic [IDXW-1:0]    w_free_idx;
  logic [SLOTW-1:0]   w_new_slot;
  logic [SLOTW-1:0]   w_cur_slot;
  logic [TYPELEN-1:0] w_cur_type;
  logic [XLEN-1:0]    w_cur_x;
  logic [15:0]        w_lfsr_next;

  // No handshake: a request is a rising edge of togenerate, a tick is a one-cycle strobe;
  // both are only accepted while halt is low and otherwise silently ignored.
  assign w_req  = togenerate & ~r_tog_prev & ~halt;
  assign w_tick = tick & ~halt;

  // Galois form of x^16+x^14+x^13+x^11, shifting towards bit 0.
  assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);

  assign w_cur_slot  = r_slots[r_idx];
  assign w_cur_type  = w_cur_slot[SLOTW-1 -: TYPELEN];
  assign w_cur_x     = w_cur_slot[XLSB +: XLEN];
  assign o_dbg_state = r_state;

  always_comb begin
    case (r_lfsr[1:0])
      2'd2:    w_new_slot = {TYPELEN'(3), XLEN'(SPAWN_X), YLEN'(GROUND_Y - 48), WLEN'(24), HLEN'(48)};
      2'd3:    w_new_slot = {TYPELEN'(4), XLEN'(SPAWN_X), YLEN'(GROUND_Y - 80), WLEN'(32), HLEN'(24)};
      default: w_new_slot = {TYPELEN'(2), XLEN'(SPAWN_X), YLEN'(GROUND_Y - 32), WLEN'(16), HLEN'(32)};
    endcase
  end

  // Lowest-numbered empty slot wins, so scan from the top down.
  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int i = DATACOUNT - 1; i >= 0; i--) begin
      if (r_slots[i][SLOTW-1 -: TYPELEN] == '0) begin
        w_free_found = 1'b1;
        w_free_idx   = IDXW'(i);
      end
    end
  end

  always_comb begin
    gamedata = '0;
    for (int i = 0; i < DATACOUNT; i++) begin
      gamedata[i*SLOTW +: SLOTW] = r_slots[i];
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_lfsr       <= 16'hACE1;
      r_tog_prev   <= 1'b0;
      r_pend_spawn <= 1'b0;
      r_pend_move  <= 1'b0;
      active_count <= 4'd0;
      spawn_drop   <= 1'b0;
      for (int i = 0; i < DATACOUNT; i++) begin
        r_slots[i] <= '0;
      end
    end else begin
      r_lfsr     <= w_lfsr_next;
      r_tog_prev <= togenerate;
      spawn_drop <= 1'b0;

      if (w_req) begin
        if (r_pend_spawn) spawn_drop <= 1'b1;
        else              r_pend_spawn <= 1'b1;
      end
      if (w_tick) r_pend_move <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (!halt) begin
            if (r_pend_spawn) begin
              r_state <= S_SPAWN;
            end else if (r_pend_move) begin
              r_state <= S_MOVE;
              r_idx   <= '0;
            end
          end
        end
        S_SPAWN: begin
          if (w_free_found) begin
            r_slots[w_free_idx] <= w_new_slot;
            active_count        <= active_count + 4'd1;
          end else begin
            spawn_drop <= 1'b1;
          end
          r_pend_spawn <= 1'b0;
          r_state      <= S_IDLE;
        end
        S_MOVE: begin
          if (w_cur_type != '0) begin
            if (w_cur_x <= XLEN'(speed)) begin
              r_slots[r_idx] <= '0;
              active_count   <= active_count - 4'd1;
            end else begin
              r_slots[r_idx][XLSB +: XLEN] <= w_cur_x - XLEN'(speed);
            end
          end
          // A tick landing on the final slot merges into the pass that is ending.
          if (r_idx == IDXW'(DATACOUNT - 1)) begin
            r_pend_move <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_enemy_spawner.sv
// Testbench for enemy_spawner: directed and random spawn/tick traffic checked against a
// table-level reference model through an expected-result queue and an independent monitor.
`timescale 1ns/1ps
module tb_enemy_spawner;
  localparam int N   = 8;
  localparam int SW  = 34;
  localparam int GDW = SW * N;
  localparam int RW  = GDW + 5;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SPAWN = 2'd1;
  localparam logic [1:0] ST_MOVE  = 2'd2;

  logic           clock = 1'b0;
  logic           rst = 1'b1;
  logic           togenerate = 1'b0;
  logic           tick = 1'b0;
  logic           halt = 1'b0;
  logic [3:0]     speed = 4'd0;
  logic [GDW-1:0] gamedata;
  logic [3:0]     active_count;
  logic           spawn_drop;
  logic [1:0]     dbg_state;

  int n_checks   = 0;
  int n_errors   = 0;
  int exp_drops  = 0;
  int drops_seen = 0;
  logic [RW-1:0] exp_q[$];

  // Reference model: one record per slot, plus the request-order LFSR.
  logic [2:0]  m_type [N];
  logic [9:0]  m_x    [N];
  logic [8:0]  m_y    [N];
  logic [5:0]  m_w    [N];
  logic [5:0]  m_h    [N];
  logic [15:0] m_lfsr;

  enemy_spawner dut (
    .clock        (clock),
    .rst          (rst),
    .togenerate   (togenerate),
    .tick         (tick),
    .speed        (speed),
    .halt         (halt),
    .gamedata     (gamedata),
    .active_count (active_count),
    .spawn_drop   (spawn_drop),
    .o_dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at 500000 ns, limit 500000 ns");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  always @(posedge clock) m_lfsr <= rst ? 16'hACE1 : lfsr_step(m_lfsr);

  function automatic logic [15:0] lfsr_ahead(input int n);
    logic [15:0] v;
    v = m_lfsr;
    for (int i = 0; i < n; i++) v = lfsr_step(v);
    return v;
  endfunction

  function automatic logic [GDW-1:0] pack_model();
    logic [GDW-1:0] g;
    g = '0;
    for (int i = 0; i < N; i++) g[i*SW +: SW] = {m_type[i], m_x[i], m_y[i], m_w[i], m_h[i]};
    return g;
  endfunction

  function automatic logic [3:0] count_of(input logic [GDW-1:0] g);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < N; i++) if (g[i*SW+31 +: 3] != 3'd0) c = c + 4'd1;
    return c;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_type[i] = 0; m_x[i] = 0; m_y[i] = 0; m_w[i] = 0; m_h[i] = 0;
    end
  endtask

  task automatic model_spawn(input logic [15:0] l);
    int f;
    logic drop;
    logic [GDW-1:0] g;
    f = -1;
    drop = 1'b0;
    for (int i = 0; i < N; i++) if (m_type[i] == 3'd0 && f < 0) f = i;
    if (f < 0) begin
      drop = 1'b1;
      exp_drops++;
    end else begin
      m_x[f] = 10'd640;
      case (l[1:0])
        2'd2:    begin m_type[f] = 3'd3; m_w[f] = 6'd24; m_h[f] = 6'd48; m_y[f] = 9'd352; end
        2'd3:    begin m_type[f] = 3'd4; m_w[f] = 6'd32; m_h[f] = 6'd24; m_y[f] = 9'd320; end
        default: begin m_type[f] = 3'd2; m_w[f] = 6'd16; m_h[f] = 6'd32; m_y[f] = 9'd368; end
      endcase
    end
    g = pack_model();
    exp_q.push_back({drop, count_of(g), g});
  endtask

  task automatic model_move(input logic [3:0] s);
    logic [GDW-1:0] g;
    for (int i = 0; i < N; i++) begin
      if (m_type[i] != 3'd0) begin
        if (m_x[i] <= {6'd0, s}) begin
          m_type[i] = 0; m_x[i] = 0; m_y[i] = 0; m_w[i] = 0; m_h[i] = 0;
        end else begin
          m_x[i] = m_x[i] - {6'd0, s};
        end
      end
    end
    g = pack_model();
    exp_q.push_back({1'b0, count_of(g), g});
  endtask

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [1:0]    prev;
    logic [RW-1:0] e;
    prev = ST_IDLE;
    forever begin
      @(posedge clock);
      #1;
      if (rst) begin
        prev = ST_IDLE;
      end else begin
        if (spawn_drop === 1'b1) drops_seen++;
        if (prev != ST_IDLE && dbg_state == ST_IDLE) begin
          if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_completion: table %h with nothing expected", gamedata);
          end else begin
            e = exp_q.pop_front();
            chk("table_after_op", {spawn_drop, active_count, gamedata}, e);
          end
        end
        prev = dbg_state;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clock);
    rst = 1'b1;
    exp_q.delete();
    model_clear();
    repeat (2) @(negedge clock);
    rst = 1'b0;
  endtask

  task automatic do_spawn(input bit with_tick, input logic [3:0] s);
    @(negedge clock);
    model_spawn(lfsr_ahead(2));
    togenerate = 1'b1;
    if (with_tick) begin
      tick  = 1'b1;
      speed = s;
      model_move(s);
    end
    @(negedge clock);
    togenerate = 1'b0;
    tick = 1'b0;
    @(negedge clock);
    chk("spawn_state", RW'(dbg_state), RW'(ST_SPAWN));
    @(negedge clock);
    if (with_tick) begin
      @(negedge clock);
      chk("move_after_spawn", RW'(dbg_state), RW'(ST_MOVE));
      repeat (9) @(negedge clock);
    end
  endtask

  task automatic tick_op(input logic [3:0] s);
    logic [GDW-1:0] pre, post, mix;
    @(negedge clock);
    pre = pack_model();
    model_move(s);
    post = pack_model();
    tick  = 1'b1;
    speed = s;
    @(negedge clock);
    tick = 1'b0;
    @(negedge clock);
    chk("move_state", RW'(dbg_state), RW'(ST_MOVE));
    chk("move_start_table", RW'(gamedata), RW'(pre));
    for (int i = 0; i < N; i++) begin
      @(negedge clock);
      for (int j = 0; j < N; j++) mix[j*SW +: SW] = (j <= i) ? post[j*SW +: SW] : pre[j*SW +: SW];
      chk("move_slot_progress", RW'({active_count, gamedata}), RW'({count_of(mix), mix}));
    end
    chk("idle_after_pass", RW'(dbg_state), RW'(ST_IDLE));
  endtask

  task automatic move_with_requests(input logic [3:0] s);
    logic [15:0] l;
    @(negedge clock);
    l = lfsr_ahead(11);
    model_move(s);
    model_spawn(l);
    exp_drops++;
    tick  = 1'b1;
    speed = s;
    @(negedge clock);
    tick = 1'b0;
    @(negedge clock);
    togenerate = 1'b1;
    @(negedge clock);
    togenerate = 1'b0;
    @(negedge clock);
    chk("no_drop_before", RW'(spawn_drop), RW'(0));
    togenerate = 1'b1;
    @(negedge clock);
    chk("drop_at_latch", RW'(spawn_drop), RW'(1));
    togenerate = 1'b0;
    repeat (8) @(negedge clock);
  endtask

  task automatic halt_test(input logic [3:0] s);
    logic [GDW-1:0] snap;
    @(negedge clock);
    model_spawn(lfsr_ahead(2));
    snap = pack_model();
    togenerate = 1'b1;
    @(negedge clock);
    togenerate = 1'b0;
    tick  = 1'b1;
    speed = s;
    model_move(s);
    @(negedge clock);
    tick = 1'b0;
    halt = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      tick       = (c == 4);
      togenerate = (c == 4);
      chk("halt_frozen", RW'({active_count, gamedata}), RW'({count_of(snap), snap}));
    end
    chk("halt_idle", RW'(dbg_state), RW'(ST_IDLE));
    halt = 1'b0;
    repeat (12) @(negedge clock);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [15:0] l;
    int tries;
    model_clear();
    repeat (3) @(negedge clock);
    chk("reset_outputs", RW'({spawn_drop, active_count, gamedata}), RW'(0));
    chk("reset_state", RW'(dbg_state), RW'(ST_IDLE));
    rst = 1'b0;

    // First enemy of kind 2 (large cactus) into slot 0.
    tries = 0;
    l = lfsr_ahead(3);
    while (l[1:0] != 2'd2 && tries < 200) begin
      @(negedge clock);
      tries++;
      l = lfsr_ahead(3);
    end
    do_spawn(1'b0, 4'd0);
    chk("first_enemy", RW'(gamedata[SW-1:0]), RW'({3'd3, 10'd640, 9'd352, 6'd24, 6'd48}));
    chk("first_count", RW'(active_count), RW'(1));

    // Three enemies scrolled by 5.
    repeat (2) do_spawn(1'b0, 4'd0);
    tick_op(4'd5);
    for (int i = 0; i < 3; i++) chk("x_after_tick", RW'(gamedata[i*SW+21 +: 10]), RW'(635));
    chk("upper_slots_empty", RW'(gamedata[GDW-1:3*SW]), RW'(0));

    // Walk one enemy down to x=4, then retire it with speed 4.
    do_reset();
    do_spawn(1'b0, 4'd0);
    repeat (42) tick_op(4'd15);
    tick_op(4'd6);
    chk("x_at_four", RW'(gamedata[21 +: 10]), RW'(4));
    tick_op(4'd4);
    chk("retired_count", RW'(active_count), RW'(0));
    chk("retired_table", RW'(gamedata), RW'(0));

    // Full table, then one more request.
    do_reset();
    repeat (8) do_spawn(1'b0, 4'd0);
    chk("full_count", RW'(active_count), RW'(8));
    do_spawn(1'b0, 4'd0);
    chk("full_after_drop", RW'(active_count), RW'(8));

    // Requests during a pass; simultaneous request and tick; halt.
    do_reset();
    repeat (2) do_spawn(1'b0, 4'd0);
    move_with_requests(4'd3);
    do_spawn(1'b1, 4'd7);
    halt_test(4'd2);

    // Reset in the middle of a pass.
    @(negedge clock);
    tick  = 1'b1;
    speed = 4'd3;
    @(negedge clock);
    tick = 1'b0;
    repeat (3) @(negedge clock);
    chk("mid_pass_state", RW'(dbg_state), RW'(ST_MOVE));
    rst = 1'b1;
    exp_q.delete();
    model_clear();
    @(negedge clock);
    chk("reset_mid_pass", RW'({spawn_drop, active_count, gamedata}), RW'(0));
    chk("reset_mid_pass_state", RW'(dbg_state), RW'(ST_IDLE));
    rst = 1'b0;

    // Random traffic.
    for (int k = 0; k < 60; k++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 4)      do_spawn(1'b0, 4'd0);
      else if (r < 6) do_spawn(1'b1, 4'($urandom_range(0, 15)));
      else            tick_op(4'($urandom_range(0, 15)));
    end

    repeat (5) @(negedge clock);
    chk("queue_drained", RW'(exp_q.size()), RW'(0));
    chk("drop_pulses", RW'(drops_seen), RW'(exp_drops));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
